// File: rtl/rv32i_defs.sv
// Shared definitions for the rv32i forwarding/hazard logic: default register
// address width, operand-mux select encodings and the stall-cause enum.
package rv32i_defs;

    localparam int RF_ADDR_WIDTH_DEF = 5;

    localparam int FWD_SEL_RF = 0;

    // The completion bus sits just past the oldest forwarding stage.
    function automatic int FWD_SEL_CMPL(input int numFwd);
        return numFwd + 1;
    endfunction

    typedef enum logic [1:0] {
        NONE,
        LOAD_USE,
        SCOREBOARD,
        WAW
    } stall_cause_e;

endpackage

// File: rtl/fwu_scoreboard.sv
// Register scoreboard for variable-latency producers. Tracks which registers
// await a write on the completion bus; x0 is never pending.
module fwu_scoreboard
    import rv32i_defs::*;
#(
    parameter int ADDR_W = RF_ADDR_WIDTH_DEF,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issueValid,
    input  logic [ADDR_W-1:0]   issueRd,
    input  logic                cmplValid,
    input  logic [ADDR_W-1:0]   cmplRd,
    output logic [NUM_REGS-1:0] pending,
    output logic [NUM_REGS-1:0] pendEff
);

    logic [NUM_REGS-1:1] pendReg;
    logic [NUM_REGS-1:0] cmplMask;

    // Issue beats a same-cycle completion to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendReg <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issueValid && issueRd == ADDR_W'(r)) begin
                    pendReg[r] <= 1'b1;
                end else if (cmplValid && cmplRd == ADDR_W'(r)) begin
                    pendReg[r] <= 1'b0;
                end
            end
        end
    end

    assign pending = {pendReg, 1'b0};

    always_comb begin
        cmplMask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cmplMask[r] = cmplValid && (cmplRd == ADDR_W'(r));
        end
    end

    assign pendEff = pending & ~cmplMask;

`ifndef SYNTHESIS
    issueWhilePending : assert property (@(posedge clk) disable iff (rst)
        !(issueValid && issueRd != '0 && pending[issueRd]));
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID/EX forwarding select and stall generation for NUM_SRC operands over
// NUM_FWD stages plus a completion bus. Define FWU_PERF_EN to add stall_cnt.
module fwd_hazard_unit
    import rv32i_defs::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int NUM_FWD       = 2,
    parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    localparam int SEL_W        = $clog2(NUM_FWD + 2)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_SRC-1:0][RF_ADDR_WIDTH-1:0]   src_addr,
    input  logic [NUM_SRC-1:0]                      src_used,
    input  logic [NUM_FWD-1:0]                      fwd_valid,
    input  logic [NUM_FWD-1:0][RF_ADDR_WIDTH-1:0]   fwd_rd,
    input  logic [NUM_FWD-1:0]                      fwd_ready,
    input  logic                                    id_wr,
    input  logic [RF_ADDR_WIDTH-1:0]                id_rd,
    input  logic                                    issue_valid,
    input  logic [RF_ADDR_WIDTH-1:0]                issue_rd,
    input  logic                                    cmpl_valid,
    input  logic [RF_ADDR_WIDTH-1:0]                cmpl_rd,
    output logic [NUM_SRC-1:0][SEL_W-1:0]           fwd_sel,
    output logic                                    stall
`ifdef FWU_PERF_EN
    ,
    output logic [31:0]                             stall_cnt
`endif
);

    localparam int NUM_REGS = 2 ** RF_ADDR_WIDTH;

    logic [NUM_REGS-1:0]           pending;
    logic [NUM_REGS-1:0]           pendEff;
    logic [NUM_SRC-1:0]            stageHit;
    logic [NUM_SRC-1:0]            stageRdy;
    logic [NUM_SRC-1:0][SEL_W-1:0] stageSel;
    logic [NUM_SRC-1:0]            loadUseHit;
    logic [NUM_SRC-1:0]            sbHit;
    logic                          wawHit;
    stall_cause_e                  stallCause;

    fwu_scoreboard #(
        .ADDR_W (RF_ADDR_WIDTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issueValid (issue_valid),
        .issueRd    (issue_rd),
        .cmplValid  (cmpl_valid),
        .cmplRd     (cmpl_rd),
        .pending    (pending),
        .pendEff    (pendEff)
    );

    // Stages are scanned oldest-first so the youngest match is the one kept.
    always_comb begin
        fwd_sel    = '0;
        stageHit   = '0;
        stageRdy   = '0;
        stageSel   = '0;
        loadUseHit = '0;
        sbHit      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] && src_addr[i] != '0) begin
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_valid[k] && fwd_rd[k] == src_addr[i]) begin
                        stageHit[i] = 1'b1;
                        stageRdy[i] = fwd_ready[k];
                        stageSel[i] = SEL_W'(k + 1);
                    end
                end
                if (stageHit[i]) begin
                    if (stageRdy[i]) fwd_sel[i] = stageSel[i];
                    else             loadUseHit[i] = 1'b1;
                end else if (cmpl_valid && cmpl_rd == src_addr[i]) begin
                    fwd_sel[i] = SEL_W'(FWD_SEL_CMPL(NUM_FWD));
                end else if (pending[src_addr[i]]) begin
                    sbHit[i] = 1'b1;
                end else begin
                    fwd_sel[i] = SEL_W'(FWD_SEL_RF);
                end
            end
        end
    end

    assign wawHit = id_wr && (id_rd != '0) && pendEff[id_rd];

    always_comb begin
        stallCause = NONE;
        if (|loadUseHit)  stallCause = LOAD_USE;
        else if (|sbHit)  stallCause = SCOREBOARD;
        else if (wawHit)  stallCause = WAW;
    end

    assign stall = (stallCause != NONE);

`ifdef FWU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with default parameters (2 operands,
// 2 stages, 5-bit addresses, 2-bit selects).
module tb_fwd_hazard_unit;

    logic             clk;
    logic             rst;
    logic [1:0][4:0]  src_addr;
    logic [1:0]       src_used;
    logic [1:0]       fwd_valid;
    logic [1:0][4:0]  fwd_rd;
    logic [1:0]       fwd_ready;
    logic             id_wr;
    logic [4:0]       id_rd;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             cmpl_valid;
    logic [4:0]       cmpl_rd;
    logic [1:0][1:0]  fwd_sel;
    logic             stall;
`ifdef FWU_PERF_EN
    logic [31:0]      stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_ready   (fwd_ready),
        .id_wr       (id_wr),
        .id_rd       (id_rd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .cmpl_valid  (cmpl_valid),
        .cmpl_rd     (cmpl_rd),
        .fwd_sel     (fwd_sel),
        .stall       (stall)
`ifdef FWU_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        src_addr    = '0;
        src_used    = '0;
        fwd_valid   = '0;
        fwd_rd      = '0;
        fwd_ready   = '0;
        id_wr       = 1'b0;
        id_rd       = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        cmpl_valid  = 1'b0;
        cmpl_rd     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
        total++;
        if (fwd_sel !== 4'b0000) begin
            bad++; $display("FAIL reset_sel got=%h exp=0", fwd_sel);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stage_fwd();
        @(negedge clk);
        idle_inputs();
        fwd_valid = 2'b11; fwd_rd[0] = 5'd5; fwd_rd[1] = 5'd5; fwd_ready = 2'b11;
        src_used = 2'b01; src_addr[0] = 5'd5; src_addr[1] = 5'd5;
        #1;
        total++;
        if (fwd_sel[0] !== 2'd1 || stall !== 1'b0) begin
            bad++; $display("FAIL stage_youngest got sel=%0d stall=%b exp sel=1 stall=0", fwd_sel[0], stall);
        end
        total++;
        if (fwd_sel[1] !== 2'd0) begin
            bad++; $display("FAIL unused_op1 got=%0d exp=0", fwd_sel[1]);
        end
        @(negedge clk);
        fwd_valid = 2'b10;
        #1;
        total++;
        if (fwd_sel[0] !== 2'd2 || stall !== 1'b0) begin
            bad++; $display("FAIL stage_older got sel=%0d stall=%b exp sel=2 stall=0", fwd_sel[0], stall);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle_inputs();
        fwd_valid = 2'b11; fwd_rd[0] = 5'd7; fwd_rd[1] = 5'd7; fwd_ready = 2'b10;
        src_used = 2'b10; src_addr[1] = 5'd7;
        #1;
        total++;
        if (stall !== 1'b1 || fwd_sel[1] !== 2'd0) begin
            bad++; $display("FAIL load_use got stall=%b sel=%0d exp stall=1 sel=0", stall, fwd_sel[1]);
        end
        @(negedge clk);
        fwd_ready = 2'b11;
        #1;
        total++;
        if (stall !== 1'b0 || fwd_sel[1] !== 2'd1) begin
            bad++; $display("FAIL load_done got stall=%b sel=%0d exp stall=0 sel=1", stall, fwd_sel[1]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL sb_issue_cycle got=%b exp=0", stall);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            issue_valid = 1'b0;
            src_used = 2'b01; src_addr[0] = 5'd9;
            #1;
            total++;
            if (stall !== 1'b1 || fwd_sel[0] !== 2'd0) begin
                bad++; $display("FAIL sb_wait%0d got stall=%b sel=%0d exp stall=1 sel=0", c, stall, fwd_sel[0]);
            end
        end
        @(negedge clk);
        cmpl_valid = 1'b1; cmpl_rd = 5'd9;
        #1;
        total++;
        if (stall !== 1'b0 || fwd_sel[0] !== 2'd3) begin
            bad++; $display("FAIL sb_cmpl got stall=%b sel=%0d exp stall=0 sel=3", stall, fwd_sel[0]);
        end
        @(negedge clk);
        cmpl_valid = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || fwd_sel[0] !== 2'd0) begin
            bad++; $display("FAIL sb_cleared got stall=%b sel=%0d exp stall=0 sel=0", stall, fwd_sel[0]);
        end
    endtask

    task automatic test_simul_waw();
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd4;
        cmpl_valid = 1'b1;  cmpl_rd = 5'd4;
        @(negedge clk);
        idle_inputs();
        id_wr = 1'b1; id_rd = 5'd4;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL waw_after_simul got=%b exp=1", stall);
        end
        @(negedge clk);
        id_wr = 1'b0;
        src_used = 2'b10; src_addr[1] = 5'd4;
        #1;
        total++;
        if (stall !== 1'b1 || fwd_sel[1] !== 2'd0) begin
            bad++; $display("FAIL raw_x4_pending got stall=%b sel=%0d exp stall=1 sel=0", stall, fwd_sel[1]);
        end
        @(negedge clk);
        src_used = 2'b00;
        id_wr = 1'b1; id_rd = 5'd4;
        cmpl_valid = 1'b1; cmpl_rd = 5'd4;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL waw_release_on_cmpl got=%b exp=0", stall);
        end
        @(negedge clk);
        cmpl_valid = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL waw_after_clear got=%b exp=0", stall);
        end
    endtask

    task automatic test_x0_unused();
        @(negedge clk);
        idle_inputs();
        fwd_valid = 2'b11; fwd_rd[0] = 5'd0; fwd_rd[1] = 5'd0; fwd_ready = 2'b00;
        src_used = 2'b11;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        total++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            bad++; $display("FAIL x0_src got stall=%b sel=%h exp stall=0 sel=0", stall, fwd_sel);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        fwd_rd[0] = 5'd3; fwd_rd[1] = 5'd3;
        src_addr[0] = 5'd3; src_addr[1] = 5'd3; src_used = 2'b00;
        #1;
        total++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            bad++; $display("FAIL unused_ops got stall=%b sel=%h exp stall=0 sel=0", stall, fwd_sel);
        end
        total++;
        if (dut.u_sb.pending[0] !== 1'b0) begin
            bad++; $display("FAIL x0_pending got=%b exp=0", dut.u_sb.pending[0]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        issue_valid = 1'b0;
        src_used = 2'b01; src_addr[0] = 5'd9;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL pre_reset_stall got=%b exp=1", stall);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL async_reset_stall got=%b exp=0", stall);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || fwd_sel[0] !== 2'd0) begin
            bad++; $display("FAIL post_reset got stall=%b sel=%0d exp stall=0 sel=0", stall, fwd_sel[0]);
        end
    endtask

`ifdef FWU_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        issue_valid = 1'b0;
        src_used = 2'b01; src_addr[0] = 5'd9;
        repeat (3) @(negedge clk);
        cmpl_valid = 1'b1; cmpl_rd = 5'd9;
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if (stall_cnt !== 32'd3) begin
            bad++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stage_fwd();
        test_load_use();
        test_scoreboard();
        test_simul_waw();
        test_x0_unused();
        test_reset_mid();
`ifdef FWU_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
